// File: rtl/int_to_fp_pipeline_hs_pkg.sv
// Shared definitions for the integer-to-float converter: rounding-mode codes
// and parameter-derived widths.
package int_to_fp_pipeline_hs_pkg;

   typedef enum logic [1:0] {
      RND_RNE = 2'b00,
      RND_RTZ = 2'b01,
      RND_RUP = 2'b10,
      RND_RDN = 2'b11
   } rnd_mode_e;

   function automatic int unsigned fp_width(input int unsigned exp_w, input int unsigned man_w);
      return 32'd1 + exp_w + man_w;
   endfunction

   function automatic int unsigned fp_bias(input int unsigned exp_w);
      return (32'd1 << (exp_w - 32'd1)) - 32'd1;
   endfunction

   function automatic int unsigned shamt_width(input int unsigned int_w);
      return $clog2(int_w);
   endfunction

endpackage

// File: rtl/int_to_fp_pipeline_hs_if.sv
// Valid/ready bus between an integer producer, the converter and the float consumer.
interface int_to_fp_pipeline_hs_if #(
   parameter int unsigned INT_W = 32,
   parameter int unsigned FP_W  = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [INT_W-1:0] int_in;
   logic             is_signed;
   logic [1:0]       rnd_mode;
   logic             out_valid;
   logic             out_ready;
   logic [FP_W-1:0]  result;
   logic             Overflow;
   logic             Inexact;

   modport master (
      output in_valid, int_in, is_signed, rnd_mode, out_ready,
      input  in_ready, out_valid, result, Overflow, Inexact
   );

   modport slave (
      input  in_valid, int_in, is_signed, rnd_mode, out_ready,
      output in_ready, out_valid, result, Overflow, Inexact
   );
endinterface

// File: rtl/int_to_fp_pipeline_hs_fp_lzc.sv
// Combinational leading-zero counter; count is only meaningful when o_zero is low.
module fp_lzc #(
   parameter int unsigned WIDTH = 32
) (
   input  logic [WIDTH-1:0]         i_data,
   output logic [$clog2(WIDTH)-1:0] o_count,
   output logic                     o_zero
);
   localparam int unsigned CNT_W = $clog2(WIDTH);

   // Highest set bit wins because later iterations overwrite earlier ones.
   always_comb begin
      o_count = CNT_W'(WIDTH - 1);
      for (int unsigned i = 0; i < WIDTH; i++) begin
         if (i_data[i]) o_count = CNT_W'(WIDTH - 1 - i);
      end
   end

   assign o_zero = ~|i_data;

endmodule

// File: rtl/int_to_fp_pipeline_hs.sv
// Three-stage signed/unsigned integer to IEEE-754 converter with valid/ready
// flow control: S1 magnitude, S2 normalise, S3 round/pack/saturate.
module int_to_fp_pipeline_hs
   import int_to_fp_pipeline_hs_pkg::*;
#(
   parameter int unsigned INT_W = 32,
   parameter int unsigned EXP_W = 8,
   parameter int unsigned MAN_W = 23
) (
   input logic                   clk,
   input logic                   rst,
   int_to_fp_pipeline_hs_if.slave bus
);
   localparam int unsigned FP_W  = fp_width(EXP_W, MAN_W);
   localparam int unsigned BIAS  = fp_bias(EXP_W);
   localparam int unsigned SHW   = shamt_width(INT_W);
   localparam int unsigned EXW   = EXP_W + SHW + 2;
   localparam int unsigned EXT_W = INT_W + MAN_W;
   localparam logic [EXW-1:0] EXP_MAX = EXW'((32'd1 << EXP_W) - 32'd1);

   // Handshake chain
   logic w_s1_adv, w_s2_adv, w_s3_adv, w_in_fire;
   logic r_s1_valid, r_s2_valid, r_s3_valid;

   assign w_s3_adv     = !r_s3_valid || bus.out_ready;
   assign w_s2_adv     = !r_s2_valid || w_s3_adv;
   assign w_s1_adv     = !r_s1_valid || w_s2_adv;
   assign w_in_fire    = bus.in_valid && w_s1_adv;
   assign bus.in_ready = w_s1_adv;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1_valid <= 1'b0;
         r_s2_valid <= 1'b0;
      end else begin
         if (w_s1_adv) r_s1_valid <= bus.in_valid;
         if (w_s2_adv) r_s2_valid <= r_s1_valid;
      end
   end

   // S1: sign and magnitude; the most-negative value maps to 2^(INT_W-1)
   logic             w_s1_sign;
   logic [INT_W-1:0] w_s1_mag;
   logic             r_s1_sign;
   logic [INT_W-1:0] r_s1_mag;
   rnd_mode_e        r_s1_rnd;

   assign w_s1_sign = bus.is_signed & bus.int_in[INT_W-1];
   assign w_s1_mag  = w_s1_sign ? (~bus.int_in + INT_W'(1)) : bus.int_in;

   always_ff @(posedge clk) begin
      if (w_in_fire) begin
         r_s1_sign <= w_s1_sign;
         r_s1_mag  <= w_s1_mag;
         r_s1_rnd  <= rnd_mode_e'(bus.rnd_mode);
      end
   end

   // S2: normalise, extract mantissa, guard and sticky
   logic [SHW-1:0]   w_lz;
   logic             w_zero;
   logic [INT_W-2:0] w_frac;
   logic [EXT_W-1:0] w_ext;

   fp_lzc #(.WIDTH(INT_W)) u_lzc (
      .i_data  (r_s1_mag),
      .o_count (w_lz),
      .o_zero  (w_zero)
   );

   assign w_frac = (INT_W-1)'(r_s1_mag << w_lz);
   assign w_ext  = {w_frac, {(MAN_W+1){1'b0}}};

   logic             r_s2_sign, r_s2_zero, r_s2_g, r_s2_s;
   logic [SHW-1:0]   r_s2_p;
   logic [MAN_W-1:0] r_s2_man;
   rnd_mode_e        r_s2_rnd;

   always_ff @(posedge clk) begin
      if (w_s2_adv && r_s1_valid) begin
         r_s2_sign <= r_s1_sign;
         r_s2_zero <= w_zero;
         r_s2_rnd  <= r_s1_rnd;
         r_s2_p    <= SHW'(INT_W - 1) - w_lz;
         r_s2_man  <= w_ext[EXT_W-1 -: MAN_W];
         r_s2_g    <= w_ext[INT_W-1];
         r_s2_s    <= |w_ext[INT_W-2:0];
      end
   end

   // S3: round, detect exponent overflow, saturate per rounding mode
   logic             w_inc, w_ovf, w_inx;
   logic [MAN_W:0]   w_man_sum;
   logic [EXW-1:0]   w_exp;
   logic [FP_W-1:0]  w_res, w_inf, w_maxf;

   always_comb begin
      w_inc = 1'b0;
      case (r_s2_rnd)
         RND_RNE: w_inc = r_s2_g & (r_s2_s | r_s2_man[0]);
         RND_RTZ: w_inc = 1'b0;
         RND_RUP: w_inc = (r_s2_g | r_s2_s) & ~r_s2_sign;
         RND_RDN: w_inc = (r_s2_g | r_s2_s) & r_s2_sign;
         default: w_inc = 1'b0;
      endcase
      w_man_sum = {1'b0, r_s2_man} + (MAN_W+1)'(w_inc);
      w_exp     = EXW'(BIAS) + EXW'(r_s2_p) + EXW'(w_man_sum[MAN_W]);
      w_ovf     = (w_exp >= EXP_MAX);
      w_inx     = r_s2_g | r_s2_s;
      w_inf     = {r_s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      w_maxf    = {r_s2_sign, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
      w_res     = {r_s2_sign, w_exp[EXP_W-1:0], w_man_sum[MAN_W-1:0]};
      if (r_s2_zero) begin
         w_res = '0;
         w_inx = 1'b0;
         w_ovf = 1'b0;
      end else if (w_ovf) begin
         w_inx = 1'b1;
         case (r_s2_rnd)
            RND_RNE: w_res = w_inf;
            RND_RTZ: w_res = w_maxf;
            RND_RUP: w_res = r_s2_sign ? w_maxf : w_inf;
            RND_RDN: w_res = r_s2_sign ? w_inf : w_maxf;
            default: w_res = w_inf;
         endcase
      end
   end

   logic [FP_W-1:0] r_result;
   logic            r_ovf, r_inx;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_s3_valid <= 1'b0;
         r_result   <= '0;
         r_ovf      <= 1'b0;
         r_inx      <= 1'b0;
      end else if (w_s3_adv) begin
         r_s3_valid <= r_s2_valid;
         if (r_s2_valid) begin
            r_result <= w_res;
            r_ovf    <= w_ovf;
            r_inx    <= w_inx;
         end
      end
   end

   assign bus.out_valid = r_s3_valid;
   assign bus.result    = r_result;
   assign bus.Overflow  = r_ovf;
   assign bus.Inexact   = r_inx;

endmodule

// File: tb/tb_int_to_fp_pipeline_hs.sv
// Directed and randomized-handshake checks of the int-to-float converter in
// single- and half-precision configurations.
module tb_int_to_fp_pipeline_hs;
   import int_to_fp_pipeline_hs_pkg::*;

   localparam int NRAND = 1000;

   logic clk = 1'b0;
   logic rst;
   int   vectors = 0;
   int   miscompares = 0;

   always #5 clk = ~clk;

   int_to_fp_pipeline_hs_if #(.INT_W(32), .FP_W(32)) bus ();
   int_to_fp_pipeline_hs_if #(.INT_W(32), .FP_W(16)) hbus ();

   int_to_fp_pipeline_hs #(.INT_W(32), .EXP_W(8), .MAN_W(23)) u_dut (
      .clk (clk), .rst (rst), .bus (bus)
   );
   int_to_fp_pipeline_hs #(.INT_W(32), .EXP_W(5), .MAN_W(10)) u_dut_h (
      .clk (clk), .rst (rst), .bus (hbus)
   );

   // Independent FP32 reference: {Overflow, Inexact, result}
   function automatic logic [33:0] model(input logic [31:0] v, input logic sg, input logic [1:0] rm);
      longint unsigned mag, trunc, rem, half;
      bit neg, inc, inx;
      int p, sh, e;
      neg = sg && v[31];
      mag = neg ? (64'h1_0000_0000 - {32'b0, v}) : {32'b0, v};
      if (mag == 0) return 34'b0;
      p = 0;
      for (int i = 0; i < 33; i++) if (mag[i]) p = i;
      inc = 0; inx = 0;
      if (p <= 23) trunc = mag << (23 - p);
      else begin
         sh    = p - 23;
         trunc = mag >> sh;
         rem   = mag & ((64'd1 << sh) - 1);
         half  = 64'd1 << (sh - 1);
         inx   = (rem != 0);
         case (rm)
            2'd0: inc = (rem > half) || (rem == half && trunc[0]);
            2'd1: inc = 0;
            2'd2: inc = inx && !neg;
            default: inc = inx && neg;
         endcase
      end
      trunc = trunc + longint'(inc);
      e = 127 + p;
      if (trunc == (64'd1 << 24)) begin trunc = 64'd1 << 23; e++; end
      return {1'b0, inx, neg, 8'(e), 23'(trunc)};
   endfunction

   function automatic logic [31:0] rand_val();
      logic [31:0] c [6] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h01000001};
      case ($urandom_range(0, 4))
         0: return $urandom();
         1: return 32'($urandom_range(0, 300));
         2: return ~32'($urandom_range(0, 300));
         3: return c[$urandom_range(0, 5)];
         default: return $urandom() >> $urandom_range(0, 31);
      endcase
   endfunction

   // Single transaction on the FP32 instance; lat = cycles from acceptance to out_valid, -1 if never accepted
   task automatic run_one(input logic [31:0] v, input logic sg, input logic [1:0] rm,
                          output logic [31:0] res, output logic ov, output logic ix, output int lat);
      int n = 0;
      @(posedge clk); #1;
      bus.in_valid = 1'b1; bus.int_in = v; bus.is_signed = sg; bus.rnd_mode = rm; bus.out_ready = 1'b1;
      @(negedge clk);
      while (!bus.in_ready && n < 50) begin @(negedge clk); n++; end
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      if (n >= 50) begin lat = -1; res = 'x; ov = 1'bx; ix = 1'bx; return; end
      @(negedge clk); lat = 1;
      while (!bus.out_valid && lat < 50) begin @(negedge clk); lat++; end
      res = bus.result; ov = bus.Overflow; ix = bus.Inexact;
   endtask

   task automatic run_one_h(input logic [31:0] v, input logic sg, input logic [1:0] rm,
                            output logic [15:0] res, output logic ov, output logic ix, output int lat);
      int n = 0;
      @(posedge clk); #1;
      hbus.in_valid = 1'b1; hbus.int_in = v; hbus.is_signed = sg; hbus.rnd_mode = rm; hbus.out_ready = 1'b1;
      @(negedge clk);
      while (!hbus.in_ready && n < 50) begin @(negedge clk); n++; end
      @(posedge clk); #1;
      hbus.in_valid = 1'b0;
      if (n >= 50) begin lat = -1; res = 'x; ov = 1'bx; ix = 1'bx; return; end
      @(negedge clk); lat = 1;
      while (!hbus.out_valid && lat < 50) begin @(negedge clk); lat++; end
      res = hbus.result; ov = hbus.Overflow; ix = hbus.Inexact;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.in_valid = 1'b0;  bus.int_in = '0;  bus.is_signed = 1'b0;  bus.rnd_mode = 2'b00;  bus.out_ready = 1'b1;
      hbus.in_valid = 1'b0; hbus.int_in = '0; hbus.is_signed = 1'b0; hbus.rnd_mode = 2'b00; hbus.out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      vectors++;
      if ({bus.out_valid, bus.result, bus.Overflow, bus.Inexact, bus.in_ready} !== {1'b0, 32'h0, 1'b0, 1'b0, 1'b1}) begin
         miscompares++;
         $display("FAIL reset_state: got v=%b r=%h o=%b i=%b rdy=%b expected v=0 r=00000000 o=0 i=0 rdy=1",
                  bus.out_valid, bus.result, bus.Overflow, bus.Inexact, bus.in_ready);
      end
      vectors++;
      if (hbus.out_valid !== 1'b0 || hbus.result !== 16'h0) begin
         miscompares++;
         $display("FAIL reset_state_half: got v=%b r=%h expected v=0 r=0000", hbus.out_valid, hbus.result);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] vals [5] = '{32'h0, 32'h1, 32'hFFFFFFFB, 32'h7FFFFFFF, 32'h80000000};
      logic [31:0] exps [5] = '{32'h00000000, 32'h3F800000, 32'hC0A00000, 32'h4F000000, 32'hCF000000};
      logic        inxs [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      logic        ev;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk); #1;
         bus.out_ready = 1'b1;
         if (k < 5) begin
            bus.in_valid = 1'b1; bus.int_in = vals[k]; bus.is_signed = 1'b1; bus.rnd_mode = RND_RNE;
         end else bus.in_valid = 1'b0;
         @(negedge clk);
         if (k < 5) begin
            vectors++;
            if (bus.in_ready !== 1'b1) begin
               miscompares++;
               $display("FAIL b2b_in_ready[%0d]: got %b expected 1", k, bus.in_ready);
            end
         end
         ev = (k >= 3 && k < 8);
         vectors++;
         if (bus.out_valid !== ev) begin
            miscompares++;
            $display("FAIL b2b_out_valid[cycle %0d]: got %b expected %b", k, bus.out_valid, ev);
         end else if (ev) begin
            vectors++;
            if ({bus.result, bus.Overflow, bus.Inexact} !== {exps[k-3], 1'b0, inxs[k-3]}) begin
               miscompares++;
               $display("FAIL b2b_result[%0d]: got %h o=%b i=%b expected %h o=0 i=%b",
                        k - 3, bus.result, bus.Overflow, bus.Inexact, exps[k-3], inxs[k-3]);
            end
         end
      end
   endtask

   task automatic test_rounding();
      logic [31:0] vals [5] = '{32'd16777217, 32'd16777217, 32'd16777217, 32'hFEFFFFFF, 32'hFEFFFFFF};
      logic [1:0]  rms  [5] = '{RND_RNE, RND_RTZ, RND_RUP, RND_RDN, RND_RUP};
      logic [31:0] exps [5] = '{32'h4B800000, 32'h4B800000, 32'h4B800001, 32'hCB800001, 32'hCB800000};
      logic [31:0] res; logic ov, ix; int lat;
      for (int k = 0; k < 5; k++) begin
         run_one(vals[k], 1'b1, rms[k], res, ov, ix, lat);
         vectors++;
         if (lat != 3 || {res, ov, ix} !== {exps[k], 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL rounding[%0d]: got %h o=%b i=%b lat=%0d expected %h o=0 i=1 lat=3",
                     k, res, ov, ix, lat, exps[k]);
         end
      end
   endtask

   task automatic test_unsigned();
      logic [31:0] res; logic ov, ix; int lat;
      run_one(32'hFFFFFFFF, 1'b0, RND_RNE, res, ov, ix, lat);
      vectors++;
      if (lat != 3 || {res, ov, ix} !== {32'h4F800000, 1'b0, 1'b1}) begin
         miscompares++;
         $display("FAIL unsigned_ffffffff: got %h o=%b i=%b lat=%0d expected 4f800000 o=0 i=1 lat=3", res, ov, ix, lat);
      end
      run_one(32'hFFFFFFFF, 1'b1, RND_RNE, res, ov, ix, lat);
      vectors++;
      if (lat != 3 || {res, ov, ix} !== {32'hBF800000, 1'b0, 1'b0}) begin
         miscompares++;
         $display("FAIL signed_ffffffff: got %h o=%b i=%b lat=%0d expected bf800000 o=0 i=0 lat=3", res, ov, ix, lat);
      end
   endtask

   task automatic test_half();
      logic [31:0] vals [5] = '{32'd65504, 32'd65519, 32'd65520, 32'd100000, 32'hFFFE7960};
      logic [1:0]  rms  [5] = '{RND_RNE, RND_RNE, RND_RNE, RND_RTZ, RND_RUP};
      logic [15:0] exps [5] = '{16'h7BFF, 16'h7BFF, 16'h7C00, 16'h7BFF, 16'hFBFF};
      logic        eov  [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      logic        eix  [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      logic [15:0] res; logic ov, ix; int lat;
      for (int k = 0; k < 5; k++) begin
         run_one_h(vals[k], 1'b1, rms[k], res, ov, ix, lat);
         vectors++;
         if (lat != 3 || {res, ov, ix} !== {exps[k], eov[k], eix[k]}) begin
            miscompares++;
            $display("FAIL half[%0d]: got %h o=%b i=%b lat=%0d expected %h o=%b i=%b lat=3",
                     k, res, ov, ix, lat, exps[k], eov[k], eix[k]);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] exps [5] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000};
      logic [31:0] held = '0;
      bit have = 0;
      int idx = 0, got = 0, stray = 0;
      for (int c = 0; c < 8; c++) begin
         @(posedge clk); #1;
         bus.out_ready = 1'b0;
         bus.in_valid = (idx < 5); bus.int_in = 32'(idx + 1); bus.is_signed = 1'b1; bus.rnd_mode = RND_RNE;
         @(negedge clk);
         if (bus.in_valid && bus.in_ready) idx++;
         if (bus.out_valid && !have) begin held = bus.result; have = 1; end
      end
      vectors++;
      if (idx != 3 || bus.in_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL bp_accept_count: got %0d accepted rdy=%b expected 3 accepted rdy=0", idx, bus.in_ready);
      end
      vectors++;
      if (bus.out_valid !== 1'b1 || bus.result !== held || held !== exps[0]) begin
         miscompares++;
         $display("FAIL bp_hold: got v=%b r=%h first=%h expected v=1 r=%h", bus.out_valid, bus.result, held, exps[0]);
      end
      for (int c = 0; c < 30 && got < 5; c++) begin
         @(posedge clk); #1;
         bus.out_ready = 1'b1;
         bus.in_valid = (idx < 5); bus.int_in = 32'(idx + 1);
         @(negedge clk);
         if (bus.in_valid && bus.in_ready) idx++;
         if (bus.out_valid) begin
            vectors++;
            if (bus.result !== exps[got]) begin
               miscompares++;
               $display("FAIL bp_order[%0d]: got %h expected %h", got, bus.result, exps[got]);
            end
            got++;
         end
      end
      @(posedge clk); #1 bus.in_valid = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (bus.out_valid) stray++;
      end
      vectors++;
      if (got != 5 || stray != 0) begin
         miscompares++;
         $display("FAIL bp_total: got %0d outputs %0d extra expected 5 outputs 0 extra", got, stray);
      end
   endtask

   task automatic test_random();
      logic [33:0] q[$];
      logic [33:0] e;
      logic [31:0] held_res = '0;
      bit hold = 0, pending = 0;
      int sent = 0, got = 0, cyc = 0;
      while (got < NRAND && cyc < 20000) begin
         @(posedge clk); #1;
         if (!pending) begin
            if (sent < NRAND && $urandom_range(0, 3) != 0) begin
               bus.in_valid  = 1'b1;
               bus.int_in    = rand_val();
               bus.is_signed = 1'($urandom_range(0, 1));
               bus.rnd_mode  = 2'($urandom_range(0, 3));
            end else bus.in_valid = 1'b0;
         end
         bus.out_ready = ($urandom_range(0, 2) != 0);
         @(negedge clk);
         cyc++;
         if (hold) begin
            vectors++;
            if (bus.out_valid !== 1'b1 || bus.result !== held_res) begin
               miscompares++;
               $display("FAIL rand_stall_stable: got v=%b r=%h expected v=1 r=%h", bus.out_valid, bus.result, held_res);
            end
         end
         if (bus.in_valid && bus.in_ready) begin
            q.push_back(model(bus.int_in, bus.is_signed, bus.rnd_mode));
            sent++;
         end
         pending = bus.in_valid && !bus.in_ready;
         if (bus.out_valid && bus.out_ready) begin
            vectors++;
            if (q.size() == 0) begin
               miscompares++;
               $display("FAIL rand_unexpected: got output %h expected none", bus.result);
            end else begin
               e = q.pop_front();
               if ({bus.Overflow, bus.Inexact, bus.result} !== e) begin
                  miscompares++;
                  $display("FAIL rand[%0d]: got %h o=%b i=%b expected %h o=%b i=%b",
                           got, bus.result, bus.Overflow, bus.Inexact, e[31:0], e[33], e[32]);
               end
            end
            got++;
         end
         hold = bus.out_valid && !bus.out_ready;
         held_res = bus.result;
      end
      @(posedge clk); #1 bus.in_valid = 1'b0; bus.out_ready = 1'b1;
      vectors++;
      if (got != NRAND || q.size() != 0) begin
         miscompares++;
         $display("FAIL rand_total: got %0d outputs %0d pending expected %0d outputs 0 pending", got, q.size(), NRAND);
      end
   endtask

   task automatic test_reset_midstream();
      logic [31:0] res; logic ov, ix; int lat;
      int cnt = 0, stray = 0;
      for (int c = 0; c < 20 && cnt < 3; c++) begin
         @(posedge clk); #1;
         bus.out_ready = 1'b0;
         bus.in_valid = 1'b1; bus.int_in = 32'(11 + cnt); bus.is_signed = 1'b1; bus.rnd_mode = RND_RNE;
         @(negedge clk);
         if (bus.in_ready) cnt++;
      end
      @(posedge clk); #1;
      bus.in_valid = 1'b0; rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; bus.out_ready = 1'b1;
      @(negedge clk);
      vectors++;
      if (cnt != 3 || bus.out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL midreset_flush: got %0d in flight v=%b expected 3 in flight v=0", cnt, bus.out_valid);
      end
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (bus.out_valid) stray++;
      end
      vectors++;
      if (stray != 0) begin
         miscompares++;
         $display("FAIL midreset_stray: got %0d outputs expected 0", stray);
      end
      run_one(32'd100, 1'b1, RND_RNE, res, ov, ix, lat);
      vectors++;
      if (lat != 3 || {res, ov, ix} !== {32'h42C80000, 1'b0, 1'b0}) begin
         miscompares++;
         $display("FAIL midreset_recover: got %h o=%b i=%b lat=%0d expected 42c80000 o=0 i=0 lat=3", res, ov, ix, lat);
      end
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_rounding();
      test_unsigned();
      test_half();
      test_backpressure();
      test_random();
      test_reset_midstream();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
